// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode: DEPTH entries of {instr, pc},
// combinational decode of the head, precise trap reporting and redirect flush.
package decode_queue_pkg;
  typedef enum logic [1:0] {REG_RF = 2'd0, IMM = 2'd1, ZERO = 2'd2, PC = 2'd3} e_op_sel_t;
  typedef enum logic [1:0] {NO_LSU = 2'd0, LSU_LOAD = 2'd1, LSU_STORE = 2'd2} e_lsu_t;

  localparam logic [2:0] ADD_SUB = 3'd0;
  localparam logic [2:0] SLL     = 3'd1;
  localparam logic [2:0] SR      = 3'd5;

  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_JAL      = 7'h6f;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [31:0] pc_dec;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        we_rd;
    e_op_sel_t   rs1_op;
    e_op_sel_t   rs2_op;
    e_lsu_t      lsu;
    logic [2:0]  f3;
    logic        alt;
    logic        jump;
    logic        branch;
  } s_id_ex_t;

  localparam s_id_ex_t ID_EX_NOP = '{pc_dec: '0, imm: '0, rd: '0, we_rd: 1'b0,
                                     rs1_op: REG_RF, rs2_op: IMM, lsu: NO_LSU,
                                     f3: ADD_SUB, alt: 1'b0, jump: 1'b0, branch: 1'b0};
endpackage

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter bit          CHECK_FUNCT   = 1'b1,
  parameter bit          SUPPORT_DEBUG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_i,
  input  logic [31:0]            pc_jump_i,
  input  logic [31:0]            pc_reset_i,
  input  logic                   stall_i,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [31:0]            fetch_instr_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output s_id_ex_t               id_ex_o,
  output logic [4:0]             rs1_addr_o,
  output logic [4:0]             rs2_addr_o,
  output logic                   trap_valid_o,
  output logic [3:0]             trap_cause_o,
  output logic [31:0]            trap_tval_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, occ_ff;
  logic [31:0] pc_next_ff;
  logic        empty, full, push, pop;

  logic [31:0] head_instr, head_pc;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  s_id_ex_t    dec;
  logic        illegal, is_ecall, is_ebreak, head_trap;
  logic [3:0]  cause;
  logic [31:0] tval;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready is also held low while in reset so every output reads 0 there.
  assign fetch_ready_o = rst & ~full & ~jump_i;
  assign id_valid_o    = ~empty & ~head_trap & ~stall_i & ~jump_i;
  assign trap_valid_o  = ~empty & head_trap & ~jump_i;
  assign push          = fetch_valid_i & fetch_ready_o;
  assign pop           = id_valid_o & id_ready_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ_ff     <= '0;
      pc_next_ff <= pc_reset_i;
    end else if (jump_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ_ff     <= '0;
      pc_next_ff <= pc_jump_i;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + ONE;
        pc_next_ff <= pc_next_ff + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + ONE;
      case ({push, pop})
        2'b10:   occ_ff <= occ_ff + ONE;
        2'b01:   occ_ff <= occ_ff - ONE;
        default: occ_ff <= occ_ff;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr[AW-1:0]] <= fetch_instr_i;
      mem_pc[wr_ptr[AW-1:0]]    <= pc_next_ff;
    end
  end

  assign head_instr = mem_instr[rd_ptr[AW-1:0]];
  assign head_pc    = mem_pc[rd_ptr[AW-1:0]];
  assign opcode     = head_instr[6:0];
  assign rd         = head_instr[11:7];
  assign f3         = head_instr[14:12];
  assign f7         = head_instr[31:25];
  assign imm_i      = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s      = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b      = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                       head_instr[30:25], head_instr[11:8], 1'b0};
  assign imm_u      = {head_instr[31:12], 12'd0};
  assign imm_j      = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                       head_instr[20], head_instr[30:21], 1'b0};

  always_comb begin
    dec        = ID_EX_NOP;
    dec.pc_dec = head_pc;
    illegal    = 1'b0;
    is_ecall   = 1'b0;
    is_ebreak  = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.f3 = f3; dec.imm = imm_i;
        dec.alt   = (f3 == SR) && head_instr[30];
        if (CHECK_FUNCT && f3 == SLL && f7 != 7'h00) illegal = 1'b1;
        if (CHECK_FUNCT && f3 == SR && f7 != 7'h00 && f7 != 7'h20) illegal = 1'b1;
      end
      OPC_LUI: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.rs1_op = ZERO; dec.imm = imm_u;
      end
      OPC_AUIPC: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.rs1_op = PC; dec.imm = imm_u;
      end
      OPC_OP: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.f3 = f3; dec.rs2_op = REG_RF;
        dec.alt   = head_instr[30];
        if (CHECK_FUNCT && ((f7 != 7'h00 && f7 != 7'h20) ||
                            (f7 == 7'h20 && f3 != ADD_SUB && f3 != SR))) illegal = 1'b1;
      end
      OPC_JAL: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.jump = 1'b1; dec.rs1_op = PC; dec.imm = imm_j;
      end
      OPC_JALR: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.jump = 1'b1; dec.f3 = f3; dec.imm = imm_i;
        if (CHECK_FUNCT && f3 != 3'd0) illegal = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1; dec.rs2_op = REG_RF; dec.f3 = f3; dec.imm = imm_b;
        if (CHECK_FUNCT && (f3 == 3'd2 || f3 == 3'd3)) illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec.we_rd = 1'b1; dec.rd = rd; dec.lsu = LSU_LOAD; dec.f3 = f3; dec.imm = imm_i;
        if (CHECK_FUNCT && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.lsu = LSU_STORE; dec.f3 = f3; dec.imm = imm_s;
        if (CHECK_FUNCT && f3 > 3'd2) illegal = 1'b1;
      end
      OPC_MISC_MEM: begin
      end
      OPC_SYSTEM: begin
        dec.rs1_op = ZERO; dec.rs2_op = ZERO;
        is_ecall   = (head_instr == 32'h0000_0073);
        is_ebreak  = (head_instr == 32'h0010_0073);
      end
      default: illegal = 1'b1;
    endcase
    if (head_instr[1:0] != 2'b11) illegal = 1'b1;
  end

  // Illegal wins over ecall/ebreak; without debug support ebreak reports as illegal.
  always_comb begin
    head_trap = illegal | is_ecall | is_ebreak;
    if (illegal || (is_ebreak && !SUPPORT_DEBUG)) begin
      cause = 4'd2;  tval = head_instr;
    end else if (is_ecall) begin
      cause = 4'd11; tval = '0;
    end else if (is_ebreak) begin
      cause = 4'd3;  tval = head_pc;
    end else begin
      cause = 4'd0;  tval = '0;
    end
  end

  assign id_ex_o      = id_valid_o ? dec : ID_EX_NOP;
  assign rs1_addr_o   = empty ? '0 : head_instr[19:15];
  assign rs2_addr_o   = empty ? '0 : head_instr[24:20];
  assign trap_cause_o = trap_valid_o ? cause : '0;
  assign trap_tval_o  = trap_valid_o ? tval : '0;
  assign occupancy_o  = occ_ff;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: a queue-level reference model checked every
// cycle, plus hand-computed expectations along the directed sequence.
module tb_decode_queue;
  import decode_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, jump_i, stall_i, fetch_valid_i, id_ready_i;
  logic [31:0] pc_jump_i, pc_reset_i, fetch_instr_i;
  logic        fetch_ready_o, id_valid_o, trap_valid_o;
  s_id_ex_t    id_ex_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [3:0]  trap_cause_o;
  logic [31:0] trap_tval_o;
  logic [$clog2(DEPTH):0] occupancy_o;

  int compared   = 0;
  int mismatched = 0;

  decode_queue #(.DEPTH(DEPTH), .CHECK_FUNCT(1'b1), .SUPPORT_DEBUG(1'b1)) dut (
    .clk(clk), .rst(rst), .jump_i(jump_i), .pc_jump_i(pc_jump_i), .pc_reset_i(pc_reset_i),
    .stall_i(stall_i), .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
    .fetch_instr_i(fetch_instr_i), .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .id_ex_o(id_ex_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .trap_valid_o(trap_valid_o), .trap_cause_o(trap_cause_o), .trap_tval_o(trap_tval_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned bits);
    logic [31:0] r;
    r = v << (32 - bits);
    return 32'($signed(r) >>> (32 - bits));
  endfunction

  function automatic s_id_ex_t m_nop();
    s_id_ex_t d;
    d = '0;
    d.rs1_op = REG_RF; d.rs2_op = IMM; d.lsu = NO_LSU; d.f3 = 3'd0;
    return d;
  endfunction

  function automatic logic m_illegal(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    if (w[1:0] != 2'b11) return 1'b1;
    case (w[6:0])
      7'h13: return (f3 == 3'd1 && f7 != 0) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      7'h33: return !(f7 inside {7'h00, 7'h20}) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      7'h67: return f3 != 3'd0;
      7'h63: return f3 inside {3'd2, 3'd3};
      7'h03: return f3 inside {3'd3, 3'd6, 3'd7};
      7'h23: return f3 > 3'd2;
      7'h37, 7'h17, 7'h6f, 7'h0f, 7'h73: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] m_cause(input logic [31:0] w);
    if (m_illegal(w)) return 4'd2;
    if (w == 32'h0000_0073) return 4'd11;
    if (w == 32'h0010_0073) return 4'd3;
    return 4'd0;
  endfunction

  function automatic s_id_ex_t m_decode(input logic [31:0] w, input logic [31:0] pc);
    s_id_ex_t d;
    d = m_nop();
    d.pc_dec = pc;
    case (w[6:0])
      7'h13: begin d.we_rd = 1; d.rd = w[11:7]; d.f3 = w[14:12]; d.imm = sext(w >> 20, 12);
                   d.alt = (w[14:12] == 3'd5) & w[30]; end
      7'h37: begin d.we_rd = 1; d.rd = w[11:7]; d.rs1_op = ZERO; d.imm = w & 32'hFFFF_F000; end
      7'h17: begin d.we_rd = 1; d.rd = w[11:7]; d.rs1_op = PC;   d.imm = w & 32'hFFFF_F000; end
      7'h33: begin d.we_rd = 1; d.rd = w[11:7]; d.f3 = w[14:12]; d.rs2_op = REG_RF; d.alt = w[30]; end
      7'h6f: begin d.we_rd = 1; d.rd = w[11:7]; d.jump = 1; d.rs1_op = PC;
                   d.imm = sext({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); end
      7'h67: begin d.we_rd = 1; d.rd = w[11:7]; d.jump = 1; d.f3 = w[14:12]; d.imm = sext(w >> 20, 12); end
      7'h63: begin d.branch = 1; d.rs2_op = REG_RF; d.f3 = w[14:12];
                   d.imm = sext({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); end
      7'h03: begin d.we_rd = 1; d.rd = w[11:7]; d.lsu = LSU_LOAD; d.f3 = w[14:12]; d.imm = sext(w >> 20, 12); end
      7'h23: begin d.lsu = LSU_STORE; d.f3 = w[14:12]; d.imm = sext({20'd0, w[31:25], w[11:7]}, 12); end
      7'h73: begin d.rs1_op = ZERO; d.rs2_op = ZERO; end
      default: ;
    endcase
    return d;
  endfunction

  // Reference model: queue of {instr, pc}, advanced at negedge with the inputs the next edge sees.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_valid = 0;

  always @(negedge clk) begin
    logic [31:0] w, pc, e_tval;
    logic [3:0]  e_cause;
    logic        e_empty, e_trap, e_idv, e_trv, e_frdy, e_push, e_pop;
    s_id_ex_t    e_id;
    e_empty = (mq.size() == 0);
    w  = e_empty ? 32'd0 : mq[0][63:32];
    pc = e_empty ? 32'd0 : mq[0][31:0];
    e_cause = m_cause(w);
    e_trap  = !e_empty && (e_cause != 0);
    e_idv   = !e_empty && !e_trap && !stall_i && !jump_i;
    e_trv   = e_trap && !jump_i;
    e_frdy  = rst && (mq.size() < DEPTH) && !jump_i;
    e_id    = e_idv ? m_decode(w, pc) : m_nop();
    e_tval  = (e_cause == 4'd2) ? w : (e_cause == 4'd3) ? pc : 32'd0;
    if (m_valid) begin
      chk("id_valid",    96'(id_valid_o),    96'(e_idv));
      chk("trap_valid",  96'(trap_valid_o),  96'(e_trv));
      chk("fetch_ready", 96'(fetch_ready_o), 96'(e_frdy));
      chk("occupancy",   96'(occupancy_o),   96'(mq.size()));
      chk("rs1_addr",    96'(rs1_addr_o),    96'(e_empty ? 5'd0 : w[19:15]));
      chk("rs2_addr",    96'(rs2_addr_o),    96'(e_empty ? 5'd0 : w[24:20]));
      chk("trap_cause",  96'(trap_cause_o),  96'(e_trv ? e_cause : 4'd0));
      chk("trap_tval",   96'(trap_tval_o),   96'(e_trv ? e_tval : 32'd0));
      chk("id_ex",       96'(id_ex_o),       96'(e_id));
    end
    if (!rst) begin
      mq.delete();
      m_pc    = pc_reset_i;
      m_valid = 1;
    end else if (m_valid) begin
      if (jump_i) begin
        mq.delete();
        m_pc = pc_jump_i;
      end else begin
        e_push = fetch_valid_i && e_frdy;
        e_pop  = e_idv && id_ready_i;
        if (e_pop) void'(mq.pop_front());
        if (e_push) begin
          mq.push_back({fetch_instr_i, m_pc});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  function automatic logic [31:0] mk_addi(input int r, input int v);
    return {v[11:0], 5'd0, 3'd0, r[4:0], 7'h13};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr);
    fetch_valid_i = 1'b1;
    fetch_instr_i = instr;
    step();
    fetch_valid_i = 1'b0;
  endtask

  logic [31:0] list[6];

  initial begin
    int acc, pops, held, k;
    bit a;
    rst = 0; jump_i = 0; stall_i = 0; fetch_valid_i = 0; id_ready_i = 0;
    pc_jump_i = '0; pc_reset_i = 32'h8000_0000; fetch_instr_i = '0;
    for (int i = 0; i < 6; i++) list[i] = mk_addi(i + 1, i + 10);

    // reset
    step(); step();
    @(negedge clk);
    chk("rst_occ", 96'(occupancy_o), 96'd0);
    chk("rst_fetch_ready", 96'(fetch_ready_o), 96'd0);
    chk("rst_id_valid", 96'(id_valid_o), 96'd0);
    chk("rst_trap_valid", 96'(trap_valid_o), 96'd0);
    chk("rst_id_ex_nop", 96'(id_ex_o), 96'(m_nop()));
    step();
    rst = 1;

    // ADDI x1,x0,5: one-cycle latency, no bypass
    id_ready_i = 1; fetch_valid_i = 1; fetch_instr_i = 32'h0050_0093;
    @(negedge clk);
    chk("addi_no_bypass", 96'(id_valid_o), 96'd0);
    step(); fetch_valid_i = 0;
    @(negedge clk);
    chk("addi_valid", 96'(id_valid_o), 96'd1);
    chk("addi_pc", 96'(id_ex_o.pc_dec), 96'h8000_0000);
    chk("addi_imm", 96'(id_ex_o.imm), 96'd5);
    chk("addi_we_rd", 96'(id_ex_o.we_rd), 96'd1);
    chk("addi_rd", 96'(id_ex_o.rd), 96'd1);
    chk("addi_rs1", 96'(rs1_addr_o), 96'd0);
    step();

    // fill to 4 with id_ready low, then drain in order
    id_ready_i = 0; k = 0; acc = 0;
    for (int c = 0; c < 6; c++) begin
      fetch_valid_i = 1; fetch_instr_i = list[k];
      @(negedge clk);
      a = fetch_ready_o;
      step();
      if (a) begin acc++; k++; end
    end
    @(negedge clk);
    chk("fill_accepts", 96'(acc), 96'd4);
    chk("fill_occ", 96'(occupancy_o), 96'd4);
    chk("fill_ready_low", 96'(fetch_ready_o), 96'd0);
    step();
    id_ready_i = 1; pops = 0;
    for (int c = 0; c < 40 && pops < 6; c++) begin
      fetch_valid_i = (k < 6);
      fetch_instr_i = (k < 6) ? list[k] : 32'd0;
      @(negedge clk);
      a = fetch_ready_o && fetch_valid_i;
      if (id_valid_o && id_ready_i) begin
        chk("drain_pc", 96'(id_ex_o.pc_dec), 96'(32'h8000_0004 + 32'(4 * pops)));
        chk("drain_rd", 96'(id_ex_o.rd), 96'(pops + 1));
        pops++;
      end
      step();
      if (a) k++;
    end
    fetch_valid_i = 0;
    chk("drain_count", 96'(pops), 96'd6);
    chk("drain_accepted", 96'(k), 96'd6);

    // illegal word at PC 0x8000001C: held trap, then flush to 0x100
    push_one(32'hFFFF_FFFF);
    @(negedge clk);
    chk("ill_trap_valid", 96'(trap_valid_o), 96'd1);
    chk("ill_cause", 96'(trap_cause_o), 96'd2);
    chk("ill_tval", 96'(trap_tval_o), 96'hFFFF_FFFF);
    chk("ill_id_valid", 96'(id_valid_o), 96'd0);
    held = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (trap_valid_o && !id_valid_o && trap_cause_o == 4'd2 &&
          trap_tval_o == 32'hFFFF_FFFF && occupancy_o == 1) held++;
      step();
    end
    chk("ill_held_cycles", 96'(held), 96'd10);
    jump_i = 1; pc_jump_i = 32'h100;
    @(negedge clk);
    chk("jump_trap_masked", 96'(trap_valid_o), 96'd0);
    chk("jump_ready_low", 96'(fetch_ready_o), 96'd0);
    step(); jump_i = 0;
    @(negedge clk);
    chk("flush_occ", 96'(occupancy_o), 96'd0);
    push_one(list[0]);
    @(negedge clk);
    chk("redirect_pc", 96'(id_ex_o.pc_dec), 96'h100);
    step();

    // ecall at 0x0, ebreak at 0x4
    jump_i = 1; pc_jump_i = 32'h0; step(); jump_i = 0;
    fetch_valid_i = 1; fetch_instr_i = 32'h0000_0073; step();
    fetch_instr_i = 32'h0010_0073; step(); fetch_valid_i = 0;
    @(negedge clk);
    chk("ecall_trap", 96'(trap_valid_o), 96'd1);
    chk("ecall_cause", 96'(trap_cause_o), 96'd11);
    chk("ecall_tval", 96'(trap_tval_o), 96'd0);
    chk("ecall_occ", 96'(occupancy_o), 96'd2);
    step();
    jump_i = 1; pc_jump_i = 32'h4; step(); jump_i = 0;
    push_one(32'h0010_0073);
    @(negedge clk);
    chk("ebreak_trap", 96'(trap_valid_o), 96'd1);
    chk("ebreak_cause", 96'(trap_cause_o), 96'd3);
    chk("ebreak_tval", 96'(trap_tval_o), 96'h4);
    step();
    jump_i = 1; pc_jump_i = 32'h200; step(); jump_i = 0;

    // full queue under stall
    id_ready_i = 0; fetch_valid_i = 1;
    for (int i = 0; i < 4; i++) begin fetch_instr_i = list[i]; step(); end
    fetch_valid_i = 0; stall_i = 1; id_ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_occ", 96'(occupancy_o), 96'd4);
      chk("stall_id_valid", 96'(id_valid_o), 96'd0);
      chk("stall_nop", 96'(id_ex_o), 96'(m_nop()));
      step();
    end
    stall_i = 0; pops = 0;
    for (int c = 0; c < 20 && pops < 4; c++) begin
      @(negedge clk);
      if (id_valid_o && id_ready_i) begin
        chk("unstall_pc", 96'(id_ex_o.pc_dec), 96'(32'h200 + 32'(4 * pops)));
        pops++;
      end
      step();
    end
    chk("unstall_count", 96'(pops), 96'd4);

    // jump with a simultaneous push and pop
    id_ready_i = 0; fetch_valid_i = 1;
    fetch_instr_i = list[1]; step(); fetch_instr_i = list[2]; step();
    id_ready_i = 1; jump_i = 1; pc_jump_i = 32'h300; fetch_instr_i = list[3];
    @(negedge clk);
    chk("jp_id_valid", 96'(id_valid_o), 96'd0);
    chk("jp_ready", 96'(fetch_ready_o), 96'd0);
    chk("jp_occ_before", 96'(occupancy_o), 96'd2);
    step();
    jump_i = 0; fetch_valid_i = 0; id_ready_i = 0;
    @(negedge clk);
    chk("jp_occ_after", 96'(occupancy_o), 96'd0);

    // reset in the middle of a drain
    pc_reset_i = 32'h0000_2000;
    fetch_valid_i = 1;
    for (int i = 0; i < 3; i++) begin fetch_instr_i = list[i]; step(); end
    fetch_valid_i = 0; id_ready_i = 1; step();
    rst = 0;
    @(negedge clk);
    chk("midrst_ready", 96'(fetch_ready_o), 96'd0);
    step(); rst = 1; id_ready_i = 0;
    @(negedge clk);
    chk("midrst_occ", 96'(occupancy_o), 96'd0);
    chk("midrst_id_valid", 96'(id_valid_o), 96'd0);
    push_one(list[4]);
    @(negedge clk);
    chk("midrst_valid", 96'(id_valid_o), 96'd1);
    chk("midrst_pc", 96'(id_ex_o.pc_dec), 96'h2000);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor of the in-order decode stage.
- Places a DEPTH-entry instruction queue between fetch and decode, so fetch bubbles and execute back-pressure are absorbed without combinational ready paths.
- Tracks a per-entry PC and flushes on redirect.
- Raises precise synchronous traps (illegal instruction, ecall, ebreak) instead of only flagging them.
- Drives the register-file read addresses and the decoded s_id_ex_t bundle to EXEC.

Parameters:
DEPTH, 4, queue entries; power of 2, >= 2.
CHECK_FUNCT, 1, 1 = full funct3/funct7 legality check; 0 = opcode-only check.
SUPPORT_DEBUG, 1, 1 = ebreak traps with cause 3; 0 = ebreak treated as illegal (cause 2).

Ports:
clk  in  1  core clock
rst  in  1  reset, synchronous, active-low
jump_i  in  1  redirect/flush request
pc_jump_i  in  32  redirect target PC
pc_reset_i  in  32  PC of first fetched instruction after reset
stall_i  in  1  hazard stall; holds queue head
fetch_valid_i  in  1  fetch instruction valid
fetch_ready_o  out  1  queue can accept
fetch_instr_i  in  32  raw instruction
id_valid_o  out  1  decoded head valid to EXEC
id_ready_i  in  1  EXEC accepts
id_ex_o  out  s_id_ex_t  decoded head bundle (pc_dec = entry PC)
rs1_addr_o  out  5  register-file rs1 read address (head instr[19:15])
rs2_addr_o  out  5  register-file rs2 read address (head instr[24:20])
trap_valid_o  out  1  head instruction traps
trap_cause_o  out  4  2 = illegal, 3 = breakpoint, 11 = ecall-M
trap_tval_o  out  32  instr word for illegal, PC for ebreak, 0 for ecall
occupancy_o  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (rst == 0 at clk edge):
  - queue empty; wr/rd pointers = 0; occupancy_o = 0.
  - pc_next_ff = pc_reset_i.
  - All outputs are 0 except id_ex_o, which carries the NOP encoding.
  - Reset mid-operation discards all entries.
- Storage: each entry holds {instr[31:0], pc[31:0]}. Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap.
- Push = fetch_valid_i && fetch_ready_o. Entry pc = pc_next_ff, and pc_next_ff += 4 (wraps mod 2^32).
- fetch_ready_o = ~full && ~jump_i. There is no dependence on id_ready_i. Full with a simultaneous pop still refuses the push.
- Latency: an instruction pushed in cycle N is at the head (id_valid_o or trap_valid_o) in cycle N+1 at earliest. There is no bypass when empty.
- Head decode is combinational from the head entry, using the same op/f3/imm rules as the current decode stage (OP_IMM, LUI, AUIPC, OP, JAL, JALR, BRANCH, LOAD, STORE, MISC_MEM, SYSTEM).
- head_trap is the OR of:
  - instr[1:0] != 2'b11;
  - opcode not in the supported set.
  - When CHECK_FUNCT = 1, also any of:
    - OP with f7 not in {0x00, 0x20};
    - OP with f7 = 0x20 and f3 not in {ADD_SUB, SR};
    - OP_IMM SLLI with f7 != 0;
    - OP_IMM SRLI/SRAI with f7 not in {0x00, 0x20};
    - JALR with f3 != 0;
    - BRANCH with f3 in {2, 3};
    - LOAD with f3 in {3, 6, 7};
    - STORE with f3 > 2.
  - SYSTEM 0x00000073: trap, cause 11.
  - SYSTEM 0x00100073: trap, cause 3 (cause 2 if SUPPORT_DEBUG = 0).
  - Other SYSTEM encodings pass as NOP with rs1_op = rs2_op = ZERO.
  - Illegal overrides ecall/ebreak.
- Output qualification:
  - id_valid_o = ~empty && ~head_trap && ~stall_i && ~jump_i.
  - trap_valid_o = ~empty && head_trap && ~jump_i.
  - Pop = id_valid_o && id_ready_i.
- A trapping head is never popped. It holds trap_valid_o, cause and tval stable until jump_i flushes the queue (the trap handler redirect).
- When id_valid_o = 0, id_ex_o is the NOP encoding:
  - we_rd = 0, rs1_op = REG_RF, rs2_op = IMM, lsu = NO_LSU, f3 = ADD_SUB;
  - all other fields 0.
- jump_i:
  - Same cycle: id_valid_o = trap_valid_o = fetch_ready_o = 0.
  - Next cycle: queue empty, pc_next_ff = pc_jump_i.
  - Any push or pop in that cycle is suppressed; jump_i has priority.
- stall_i: the head is held and not popped, but pushes continue while not full. id_valid_o = 0 does not clear trap_valid_o.
- Simultaneous push and pop when neither empty nor full: occupancy is unchanged.
- occupancy_o is registered.

Test Plan:
- Reset with pc_reset_i = 0x8000_0000, then push ADDI x1,x0,5 (0x00500093) with id_ready_i = 1 → next cycle id_valid_o = 1, pc_dec = 0x8000_0000, imm = 5, we_rd = 1, rs1_addr_o = 0.
- DEPTH = 4, id_ready_i = 0, push 6 instrs → fetch_ready_o drops after 4 accepts, occupancy_o = 4. Release id_ready_i → instrs drain in order, PCs +4 each, and the 5th/6th are accepted as space frees.
- Push 0xFFFFFFFF → trap_valid_o = 1, cause 2, tval 0xFFFFFFFF, id_valid_o = 0, head held over 10 cycles. Assert jump_i with pc_jump_i = 0x100 → queue empty; next push gets PC 0x100.
- Push ecall then ebreak at PCs 0x0 and 0x4 → ecall trap cause 11, tval 0. After the flush, re-push the ebreak → cause 3, tval = its PC.
- Full queue, assert stall_i for 3 cycles → no pops, occupancy stays 4, id_valid_o = 0, id_ex_o = NOP. Deassert → normal drain.
- Assert jump_i in the same cycle as a push and a pop → neither happens; occupancy_o = 0 next cycle; rst low mid-drain → occupancy_o = 0 and pc_next_ff = pc_reset_i.
